// File: rtl/wb_writeback_unit_pkg.sv
// Shared types and constants for the writeback stage of the SIMD AES pipeline.
package pipe_pkg;
    localparam int WORD_W      = 32;
    localparam int LANES       = 4;
    localparam int VEC_W       = WORD_W * LANES;
    localparam int DEF_TIMEOUT = 16;

    typedef enum logic [1:0] {SEL_ALU, SEL_MEM, SEL_SBOX, SEL_RSVD} wb_sel_t;
    typedef enum logic {IDLE, COLLECT} vec_state_t;

    // Reserved select yields zero so a stray encoding never leaks stale data.
    function automatic logic [WORD_W-1:0] wb_mux(input wb_sel_t sel,
                                                 input logic [WORD_W-1:0] alu,
                                                 input logic [WORD_W-1:0] mem,
                                                 input logic [WORD_W-1:0] sbox);
        case (sel)
            SEL_ALU:  return alu;
            SEL_MEM:  return mem;
            SEL_SBOX: return sbox;
            default:  return '0;
        endcase
    endfunction
endpackage

// File: rtl/wb_writeback_unit_if.sv
// MEM/WB inputs plus register-file write ports and forwarding outputs.
interface wb_writeback_unit_if;
    import pipe_pkg::*;

    logic [WORD_W-1:0] WB_MemData;
    logic [WORD_W-1:0] WB_ALUResult;
    logic [WORD_W-1:0] WB_sbox;
    logic [4:0]        WB_rd;
    logic [1:0]        WB_MemToReg;
    logic              WB_RegWrite;
    logic              WB_VRegWrite;

    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [WORD_W-1:0] rf_wdata;
    logic              vrf_we;
    logic [4:0]        vrf_waddr;
    logic [VEC_W-1:0]  vrf_wdata;
    logic              vec_busy;
    logic              vec_abort;
    logic              fwd_valid;
    logic [4:0]        fwd_rd;
    logic [WORD_W-1:0] fwd_data;

    modport master (
        output WB_MemData, WB_ALUResult, WB_sbox, WB_rd, WB_MemToReg, WB_RegWrite, WB_VRegWrite,
        input  rf_we, rf_waddr, rf_wdata, vrf_we, vrf_waddr, vrf_wdata, vec_busy, vec_abort,
               fwd_valid, fwd_rd, fwd_data
    );
    modport slave (
        input  WB_MemData, WB_ALUResult, WB_sbox, WB_rd, WB_MemToReg, WB_RegWrite, WB_VRegWrite,
        output rf_we, rf_waddr, rf_wdata, vrf_we, vrf_waddr, vrf_wdata, vec_busy, vec_abort,
               fwd_valid, fwd_rd, fwd_data
    );
endinterface

// File: rtl/wb_writeback_unit_vec_collector.sv
// Gathers tagged 32-bit beats into one vector-register write; aborts on tag change or idle timeout.
module vec_collector
    import pipe_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              beat_i,
    input  logic [4:0]        rd_i,
    input  logic [WORD_W-1:0] data_i,
    output logic              vrf_we_o,
    output logic [4:0]        vrf_waddr_o,
    output logic [VEC_W-1:0]  vrf_wdata_o,
    output logic              vec_busy_o,
    output logic              vec_abort_o
);
    localparam int LANE_W = $clog2(LANES);
    localparam int IDLE_W = $clog2(TIMEOUT);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT - 1);

    vec_state_t                   state_q, state_d;
    logic [LANE_W-1:0]            lane_q, lane_d;
    logic [IDLE_W-1:0]            idle_q, idle_d;
    logic [4:0]                   tag_q, tag_d;
    logic [LANES-1:0][WORD_W-1:0] lanes_q, lanes_d;
    logic                         vwe_q, vwe_d;
    logic                         abort_q, abort_d;
    logic [4:0]                   vaddr_q, vaddr_d;
    logic [VEC_W-1:0]             vdata_q, vdata_d;

    logic hit, last, timeout;
    assign hit     = beat_i && (rd_i == tag_q);
    assign last    = (lane_q == LAST_LANE);
    assign timeout = !beat_i && (idle_q == IDLE_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (beat_i) state_d = COLLECT;
            COLLECT: if ((hit && last) || timeout) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        lane_d     = lane_q;
        idle_d     = idle_q;
        tag_d      = tag_q;
        lanes_d    = lanes_q;
        vwe_d      = 1'b0;
        abort_d    = 1'b0;
        vaddr_d    = vaddr_q;
        vdata_d    = vdata_q;
        vec_busy_o = (state_q == COLLECT);
        case (state_q)
            IDLE: begin
                if (beat_i) begin
                    lanes_d[0] = data_i;
                    tag_d      = rd_i;
                    lane_d     = LANE_W'(1);
                    idle_d     = '0;
                end
            end
            COLLECT: begin
                if (hit) begin
                    lanes_d[lane_q] = data_i;
                    lane_d          = lane_q + LANE_W'(1);
                    idle_d          = '0;
                    // Final lane goes straight into the write bus alongside the stored lanes.
                    if (last) begin
                        vwe_d   = 1'b1;
                        vaddr_d = tag_q;
                        vdata_d = lanes_d;
                    end
                end else if (beat_i) begin
                    abort_d    = 1'b1;
                    lanes_d[0] = data_i;
                    tag_d      = rd_i;
                    lane_d     = LANE_W'(1);
                    idle_d     = '0;
                end else begin
                    idle_d  = idle_q + IDLE_W'(1);
                    abort_d = timeout;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lane_q  <= '0;
            idle_q  <= '0;
            tag_q   <= '0;
            lanes_q <= '0;
            vwe_q   <= 1'b0;
            abort_q <= 1'b0;
            vaddr_q <= '0;
            vdata_q <= '0;
        end else begin
            lane_q  <= lane_d;
            idle_q  <= idle_d;
            tag_q   <= tag_d;
            lanes_q <= lanes_d;
            vwe_q   <= vwe_d;
            abort_q <= abort_d;
            vaddr_q <= vaddr_d;
            vdata_q <= vdata_d;
        end
    end

    assign vrf_we_o    = vwe_q;
    assign vrf_waddr_o = vaddr_q;
    assign vrf_wdata_o = vdata_q;
    assign vec_abort_o = abort_q;
endmodule

// File: rtl/wb_writeback_unit.sv
// Writeback stage: result mux, scalar RF write port, forwarding registers, vector assembly.
module wb_writeback_unit
    import pipe_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst_n,
    wb_writeback_unit_if.slave bus
);
    wb_sel_t           sel_e;
    logic [WORD_W-1:0] sel_data;
    logic              rf_we;

    logic              fwd_valid_q, fwd_valid_d;
    logic [4:0]        fwd_rd_q, fwd_rd_d;
    logic [WORD_W-1:0] fwd_data_q, fwd_data_d;

    assign sel_e    = wb_sel_t'(bus.WB_MemToReg);
    assign sel_data = wb_mux(sel_e, bus.WB_ALUResult, bus.WB_MemData, bus.WB_sbox);
    // r0 is hardwired zero in the scalar file; gating with rst_n keeps reset writes out.
    assign rf_we    = rst_n && bus.WB_RegWrite && (bus.WB_rd != '0) && (sel_e != SEL_RSVD);

    assign bus.rf_we    = rf_we;
    assign bus.rf_waddr = bus.WB_rd;
    assign bus.rf_wdata = sel_data;

    always_comb begin
        fwd_valid_d = rf_we;
        fwd_rd_d    = rf_we ? bus.WB_rd : fwd_rd_q;
        fwd_data_d  = rf_we ? sel_data  : fwd_data_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fwd_valid_q <= 1'b0;
            fwd_rd_q    <= '0;
            fwd_data_q  <= '0;
        end else begin
            fwd_valid_q <= fwd_valid_d;
            fwd_rd_q    <= fwd_rd_d;
            fwd_data_q  <= fwd_data_d;
        end
    end

    assign bus.fwd_valid = fwd_valid_q;
    assign bus.fwd_rd    = fwd_rd_q;
    assign bus.fwd_data  = fwd_data_q;

    vec_collector #(.TIMEOUT(TIMEOUT)) u_vec (
        .clk         (clk),
        .rst_n       (rst_n),
        .beat_i      (bus.WB_VRegWrite),
        .rd_i        (bus.WB_rd),
        .data_i      (sel_data),
        .vrf_we_o    (bus.vrf_we),
        .vrf_waddr_o (bus.vrf_waddr),
        .vrf_wdata_o (bus.vrf_wdata),
        .vec_busy_o  (bus.vec_busy),
        .vec_abort_o (bus.vec_abort)
    );
endmodule

// File: doc/wb_writeback_unit.md
Name: wb_writeback_unit

Overview:
- Writeback stage of the SIMD AES pipeline. Sits at the consumer end of the MEM/WB pipeline register.
- Selects the scalar result (ALU, memory or S-box) and drives the scalar register-file write port.
- Assembles successive 32-bit vector beats into one 128-bit vector-register write.
- Provides registered forwarding info back to the EX-stage hazard logic.

Parameters:
- WORD_W, 32, width of one scalar word / vector lane
- LANES, 4, lanes per vector register (vector width = WORD_W*LANES)
- TIMEOUT, 16, idle cycles allowed between vector beats before the partial vector is aborted

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  synchronous active-low reset
- WB_MemData  in  32  load data from MEM/WB
- WB_ALUResult  in  32  ALU result from MEM/WB
- WB_sbox  in  32  S-box result from MEM/WB
- WB_rd  in  5  destination register index
- WB_MemToReg  in  2  result select: 00 ALU, 01 Mem, 10 sbox, 11 reserved
- WB_RegWrite  in  1  scalar write request
- WB_VRegWrite  in  1  vector beat valid
- rf_we  out  1  scalar register-file write enable
- rf_waddr  out  5  scalar write address
- rf_wdata  out  32  scalar write data
- vrf_we  out  1  vector register-file write enable (1-cycle pulse)
- vrf_waddr  out  5  vector write address
- vrf_wdata  out  128  assembled vector; lane0 = bits 31:0
- vec_busy  out  1  partial vector being collected
- vec_abort  out  1  1-cycle pulse: partial vector discarded
- fwd_valid  out  1  last scalar write valid for forwarding
- fwd_rd  out  5  last scalar write address
- fwd_data  out  32  last scalar write data

Behaviour:
- Reset: clk edge with rst_n=0 clears all registered outputs and state to 0 and puts the FSM in IDLE. Reset mid-collection discards the partial vector and raises no vec_abort.
- Result mux (combinational):
  - sel = ALUResult / MemData / sbox for MemToReg 00/01/10.
  - MemToReg 11 selects 32'h0 and suppresses rf_we.
- Scalar port (0-cycle latency, combinational):
  - rf_we = WB_RegWrite & (WB_rd != 0) & (MemToReg != 11).
  - rf_waddr = WB_rd; rf_wdata = sel.
  - While rst_n=0, rf_we is forced to 0.
- Forwarding (registered, 1 cycle):
  - fwd_valid/fwd_rd/fwd_data <= rf_we/WB_rd/sel each cycle.
  - When rf_we=0, fwd_valid <= 0 and rd/data hold their previous values.
- Vector FSM, states IDLE and COLLECT; lane counter lane[1:0]; idle counter idle_cnt.
  - IDLE, beat (VRegWrite=1): store sel into lane 0, latch tag=WB_rd, lane<=1, idle_cnt<=0, go to COLLECT.
  - COLLECT, beat with WB_rd==tag: store into lane[lane], lane++, idle_cnt<=0.
  - COLLECT, beat with WB_rd!=tag: pulse vec_abort, discard the partial vector, store the new beat into lane 0, tag<=WB_rd, lane<=1. Stay in COLLECT.
  - COLLECT, no beat: idle_cnt++. When idle_cnt reaches TIMEOUT-1 with no beat: pulse vec_abort, go to IDLE.
  - Final beat (lane==LANES-1): next cycle vrf_we=1 for exactly one cycle with vrf_waddr=tag and vrf_wdata = all four lanes; go to IDLE. Latency is 1 cycle after the 4th beat.
  - A beat in the same cycle as the vrf_we pulse is accepted as lane 0 of a new vector; back-to-back vectors are legal.
- vec_busy = (state==COLLECT).
- vrf_waddr/vrf_wdata hold their last values when vrf_we=0.
- Vector writes to rd=0 are allowed (the vector file has no hardwired zero).
- Scalar and vector writes in the same cycle are independent and both are honoured.
- The vector path uses the same MemToReg mux. A beat with MemToReg=11 writes 0 into its lane.

Decomposition:
- Shared package pipe_pkg holds:
  - wb_sel_t enum (SEL_ALU, SEL_MEM, SEL_SBOX, SEL_RSVD)
  - vec_state_t enum (IDLE, COLLECT)
  - WORD_W, LANES and VEC_W constants
- Vector collector is a natural sub-module: vec_collector (FSM, lane counter, timeout, 128-bit assembly). The top level keeps the mux, the scalar port and the forwarding registers.

Test Plan:
- Reset, then MemToReg=10, sbox=32'h63, rd=5, RegWrite=1 -> same cycle rf_we=1, rf_waddr=5, rf_wdata=32'h63; next cycle fwd_valid=1, fwd_rd=5, fwd_data=32'h63.
- RegWrite=1, rd=0, ALU=32'hFFFF -> rf_we=0; next cycle fwd_valid=0.
- Four consecutive vector beats to rd=2 with ALU=32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF -> one cycle after beat 4: vrf_we=1, vrf_waddr=2, vrf_wdata=128'hCCDDEEFF_8899AABB_44556677_00112233; vec_busy low afterwards.
- Two beats to rd=3, then a beat to rd=4 -> vec_abort pulses, vec_busy stays 1. Three more beats to rd=4 give vrf_we with waddr=4, and lane0 equals the rd=4 first beat.
- One beat to rd=1, then 16 idle cycles -> vec_abort pulses, FSM in IDLE, no vrf_we.
- rst_n=0 after two beats, then 4 fresh beats to rd=7 -> no vec_abort during reset, single vrf_we with waddr=7 containing only the fresh data.
